// File: rtl/vnu3_rd_fsm.sv
// Read-side sweep controller for the dual-bank VNU3 IB LUT RAM.
// Issues one read per address, tracks RAM latency, and streams {bank1,bank0} beats through a skid FIFO.
module vnu3_rd_fsm #(
    parameter  int LOAD_CYCLE     = 64,
    parameter  int DATA_WIDTH     = 4,
    parameter  int RAM_RD_LATENCY = 2,
    localparam int ADDR_WIDTH     = $clog2(LOAD_CYCLE)
) (
    input  logic                    read_clk,
    input  logic                    rstn,
    input  logic                    rd_start,
    input  logic                    rd_abort,
    input  logic [1:0]              wr_busy,
    input  logic [DATA_WIDTH-1:0]   ram_rd_data0,
    input  logic [DATA_WIDTH-1:0]   ram_rd_data1,
    input  logic                    out_ready,
    output logic                    ram_rd_en,
    output logic [ADDR_WIDTH-1:0]   ram_rd_addr,
    output logic [2*DATA_WIDTH-1:0] out_data,
    output logic                    out_valid,
    output logic                    out_last,
    output logic [1:0]              rd_busy,
    output logic [2:0]              state
);

    localparam int SKID_DEPTH = RAM_RD_LATENCY + 2;
    localparam int PTR_W      = $clog2(SKID_DEPTH);
    localparam int CNT_W      = $clog2(SKID_DEPTH + 1);
    localparam int BEAT_W     = 2 * DATA_WIDTH;

    typedef enum logic [2:0] {
        S_IDLE    = 3'b000,
        S_WAIT_WR = 3'b001,
        S_ISSUE   = 3'b010,
        S_DRAIN   = 3'b011,
        S_FINISH  = 3'b100
    } state_t;

    state_t                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [RAM_RD_LATENCY-1:0] pipe_vld_q, pipe_vld_d;
    logic [RAM_RD_LATENCY-1:0] pipe_last_q, pipe_last_d;
    logic [BEAT_W-1:0]       fifo_data_q [SKID_DEPTH];
    logic [BEAT_W-1:0]       fifo_data_d [SKID_DEPTH];
    logic                    fifo_last_q [SKID_DEPTH];
    logic                    fifo_last_d [SKID_DEPTH];
    logic [PTR_W-1:0]        wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]        rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]        fifo_cnt_q, fifo_cnt_d;

    logic [CNT_W-1:0]        inflight;
    logic [CNT_W:0]          occupancy;
    logic                    wr_hold;
    logic                    last_addr;
    logic                    issue;
    logic                    push;
    logic                    pop;

    function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(SKID_DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    always_comb begin
        inflight = '0;
        for (int i = 0; i < RAM_RD_LATENCY; i++) begin
            inflight = inflight + CNT_W'(pipe_vld_q[i]);
        end
    end

    // In-flight reads are counted as already occupying the FIFO, so it can never overflow.
    assign occupancy = {1'b0, fifo_cnt_q} + {1'b0, inflight};
    assign wr_hold   = (wr_busy == 2'b01);
    assign last_addr = (addr_q == ADDR_WIDTH'(LOAD_CYCLE - 1));
    assign issue     = (state_q == S_ISSUE) && !wr_hold && (occupancy < (CNT_W + 1)'(SKID_DEPTH));
    assign push      = pipe_vld_q[RAM_RD_LATENCY-1];
    assign pop       = out_valid && out_ready;

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        unique case (state_q)
            S_IDLE: begin
                if (rd_start) begin
                    state_d = wr_hold ? S_WAIT_WR : S_ISSUE;
                    addr_d  = '0;
                end
            end
            S_WAIT_WR: begin
                if (!wr_hold) begin
                    state_d = S_ISSUE;
                    addr_d  = '0;
                end
            end
            S_ISSUE: begin
                if (issue) begin
                    if (last_addr) begin
                        state_d = S_DRAIN;
                    end else begin
                        addr_d = addr_q + ADDR_WIDTH'(1);
                    end
                end
            end
            S_DRAIN: begin
                if (fifo_cnt_q == '0 && inflight == '0) begin
                    state_d = S_FINISH;
                end
            end
            S_FINISH: state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
        if (rd_abort) begin
            state_d = S_IDLE;
            addr_d  = '0;
        end
    end

    always_comb begin
        pipe_vld_d     = '0;
        pipe_last_d    = '0;
        pipe_vld_d[0]  = issue;
        pipe_last_d[0] = issue && last_addr;
        for (int i = 1; i < RAM_RD_LATENCY; i++) begin
            pipe_vld_d[i]  = pipe_vld_q[i-1];
            pipe_last_d[i] = pipe_last_q[i-1];
        end
        fifo_data_d = fifo_data_q;
        fifo_last_d = fifo_last_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        fifo_cnt_d  = fifo_cnt_q;
        if (rd_abort) begin
            // Clearing the valid pipe is what drops RAM data still on its way back.
            pipe_vld_d  = '0;
            pipe_last_d = '0;
            wr_ptr_d    = '0;
            rd_ptr_d    = '0;
            fifo_cnt_d  = '0;
        end else begin
            if (push) begin
                fifo_data_d[wr_ptr_q] = {ram_rd_data1, ram_rd_data0};
                fifo_last_d[wr_ptr_q] = pipe_last_q[RAM_RD_LATENCY-1];
                wr_ptr_d              = ptr_next(wr_ptr_q);
            end
            if (pop) begin
                rd_ptr_d = ptr_next(rd_ptr_q);
            end
            unique case ({push, pop})
                2'b10:   fifo_cnt_d = fifo_cnt_q + CNT_W'(1);
                2'b01:   fifo_cnt_d = fifo_cnt_q - CNT_W'(1);
                default: fifo_cnt_d = fifo_cnt_q;
            endcase
        end
    end

    always_ff @(posedge read_clk or negedge rstn) begin
        if (!rstn) begin
            state_q     <= S_IDLE;
            addr_q      <= '0;
            pipe_vld_q  <= '0;
            pipe_last_q <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            fifo_cnt_q  <= '0;
            for (int i = 0; i < SKID_DEPTH; i++) begin
                fifo_data_q[i] <= '0;
                fifo_last_q[i] <= 1'b0;
            end
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            pipe_vld_q  <= pipe_vld_d;
            pipe_last_q <= pipe_last_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            fifo_cnt_q  <= fifo_cnt_d;
            fifo_data_q <= fifo_data_d;
            fifo_last_q <= fifo_last_d;
        end
    end

    // Handshake: a beat moves when out_valid && out_ready; the FIFO head holds while stalled.
    assign ram_rd_en   = issue;
    assign ram_rd_addr = addr_q;
    assign out_valid   = (fifo_cnt_q != '0);
    assign out_data    = out_valid ? fifo_data_q[rd_ptr_q] : '0;
    assign out_last    = out_valid && fifo_last_q[rd_ptr_q];
    assign state       = state_q;

    always_comb begin
        rd_busy = 2'b01;
        if (state_q == S_IDLE) begin
            rd_busy = 2'b00;
        end else if (state_q == S_FINISH) begin
            rd_busy = 2'b10;
        end
    end

endmodule

// File: tb/tb_vnu3_rd_fsm.sv
// Randomized bench for vnu3_rd_fsm: RAM latency model, expected-beat queue filled per sweep, negedge monitor.
module tb_vnu3_rd_fsm;

    localparam int LC   = 64;
    localparam int DW   = 4;
    localparam int LAT  = 2;
    localparam int AW   = 6;
    localparam int SKID = LAT + 2;

    logic            read_clk;
    logic            rstn;
    logic            rd_start;
    logic            rd_abort;
    logic [1:0]      wr_busy;
    logic [DW-1:0]   ram_rd_data0;
    logic [DW-1:0]   ram_rd_data1;
    logic            out_ready;
    logic            ram_rd_en;
    logic [AW-1:0]   ram_rd_addr;
    logic [2*DW-1:0] out_data;
    logic            out_valid;
    logic            out_last;
    logic [1:0]      rd_busy;
    logic [2:0]      state;

    vnu3_rd_fsm #(.LOAD_CYCLE(LC), .DATA_WIDTH(DW), .RAM_RD_LATENCY(LAT)) dut (
        .read_clk     (read_clk),
        .rstn         (rstn),
        .rd_start     (rd_start),
        .rd_abort     (rd_abort),
        .wr_busy      (wr_busy),
        .ram_rd_data0 (ram_rd_data0),
        .ram_rd_data1 (ram_rd_data1),
        .out_ready    (out_ready),
        .ram_rd_en    (ram_rd_en),
        .ram_rd_addr  (ram_rd_addr),
        .out_data     (out_data),
        .out_valid    (out_valid),
        .out_last     (out_last),
        .rd_busy      (rd_busy),
        .state        (state)
    );

    int n_vec = 0;
    int n_err = 0;
    logic [2*DW:0] exp_q[$];
    logic [DW-1:0] bank0 [LC];
    logic [DW-1:0] bank1 [LC];

    int cyc = 0;
    int exp_addr, issued, popped, first_en_cyc, first_vld_cyc;
    int run_len, max_run, fin_cycles, en_win;
    bit sweep_active = 0;
    bit prev_en = 0;

    initial begin
        read_clk = 1'b0;
        forever #5 read_clk = ~read_clk;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
        n_vec++;
        if (act !== expv) begin
            n_err++;
            $display("FAIL %s: actual %0d, required %0d", nm, act, expv);
        end
    endtask

    task automatic step();
        @(posedge read_clk);
        #1;
    endtask

    // RAM model: a read sampled at a clock edge returns data LAT cycles later; junk otherwise.
    initial begin
        bit s_en;
        int s_addr;
        bit pv[LAT];
        int pa[LAT];
        for (int k = 0; k < LAT; k++) begin
            pv[k] = 0;
            pa[k] = 0;
        end
        ram_rd_data0 = '0;
        ram_rd_data1 = '0;
        forever begin
            @(negedge read_clk);
            s_en   = ram_rd_en;
            s_addr = int'(ram_rd_addr);
            @(posedge read_clk);
            #1;
            for (int k = LAT - 1; k > 0; k--) begin
                pv[k] = pv[k-1];
                pa[k] = pa[k-1];
            end
            pv[0] = s_en;
            pa[0] = s_addr;
            if (pv[LAT-1]) begin
                ram_rd_data0 = bank0[pa[LAT-1]];
                ram_rd_data1 = bank1[pa[LAT-1]];
            end else begin
                ram_rd_data0 = DW'($urandom);
                ram_rd_data1 = DW'($urandom);
            end
        end
    end

    // Monitor: address order, issue legality, skid bound and every presented beat against the queue.
    initial begin
        forever begin
            @(negedge read_clk);
            cyc++;
            if (rstn) begin
                if (ram_rd_en) begin
                    chk("rd_en_allowed", 32'(sweep_active && wr_busy != 2'b01), 32'd1);
                    chk("rd_addr", 32'(ram_rd_addr), 32'(exp_addr));
                    exp_addr++;
                    issued++;
                    en_win++;
                    chk("skid_bound", 32'(issued - popped <= SKID), 32'd1);
                    if (first_en_cyc < 0) first_en_cyc = cyc;
                    run_len = prev_en ? run_len + 1 : 1;
                    if (run_len > max_run) max_run = run_len;
                end
                prev_en = ram_rd_en;
                if (out_valid) begin
                    if (first_vld_cyc < 0) first_vld_cyc = cyc;
                    if (exp_q.size() == 0) begin
                        chk("unexpected_beat", 32'(out_valid), 32'd0);
                    end else begin
                        chk("beat", 32'({out_last, out_data}), 32'(exp_q[0]));
                        if (out_ready) begin
                            void'(exp_q.pop_front());
                            popped++;
                        end
                    end
                end
                if (rd_busy == 2'b10) begin
                    fin_cycles++;
                    chk("finish_state", 32'(state), 32'd4);
                end
            end
        end
    end

    task automatic start_sweep(input logic [1:0] wb, output int s_cyc);
        for (int a = 0; a < LC; a++) begin
            bank0[a] = DW'($urandom_range(0, 15));
            bank1[a] = DW'($urandom_range(0, 15));
            exp_q.push_back({(a == LC - 1), bank1[a], bank0[a]});
        end
        exp_addr      = 0;
        issued        = 0;
        popped        = 0;
        first_en_cyc  = -1;
        first_vld_cyc = -1;
        run_len       = 0;
        max_run       = 0;
        fin_cycles    = 0;
        sweep_active  = 1;
        s_cyc         = cyc + 1;
        wr_busy       = wb;
        rd_start      = 1'b1;
        step();
        rd_start      = 1'b0;
    endtask

    task automatic wait_done();
        int t = 0;
        while (!(fin_cycles > 0 && rd_busy == 2'b00) && t < 3000) begin
            step();
            t++;
        end
        chk("sweep_timeout", 32'(t < 3000), 32'd1);
        sweep_active = 0;
        chk("beats_delivered", 32'(popped), 32'(LC));
        chk("queue_empty", 32'(exp_q.size()), 32'd0);
        chk("finish_one_cycle", 32'(fin_cycles), 32'd1);
        chk("idle_busy", 32'(rd_busy), 32'd0);
        chk("idle_state", 32'(state), 32'd0);
    endtask

    task automatic wait_addr(input int target);
        int t = 0;
        while (exp_addr < target && t < 1000) begin
            step();
            t++;
        end
        chk("wait_addr_timeout", 32'(t < 1000), 32'd1);
    endtask

    task automatic report();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: actual timeout, required completion");
        n_err++;
        report();
        $finish;
    end

    initial begin
        int s;
        int r;
        int t;
        rstn      = 1'b0;
        rd_start  = 1'b0;
        rd_abort  = 1'b0;
        wr_busy   = 2'b00;
        out_ready = 1'b1;
        repeat (3) step();
        chk("reset_outputs", 32'({ram_rd_en, ram_rd_addr, out_valid, out_last, out_data, rd_busy, state}), 32'd0);
        rstn = 1'b1;
        step();

        // Plain sweep with an idle writer and an always-ready sink.
        start_sweep(2'b00, s);
        chk("busy_during_sweep", 32'(rd_busy), 32'd1);
        wait_done();
        chk("first_en_cycle", 32'(first_en_cyc), 32'(s + 1));
        chk("first_beat_latency", 32'(first_vld_cyc - first_en_cyc), 32'(LAT + 1));
        chk("no_bubbles", 32'(max_run), 32'(LC));

        // Start while the writer is updating.
        start_sweep(2'b01, s);
        repeat (9) step();
        chk("wait_wr_state", 32'(state), 32'd1);
        chk("wait_wr_no_issue", 32'(issued), 32'd0);
        r = cyc + 2;
        wr_busy = 2'b00;
        wait_done();
        chk("issue_after_writer", 32'(first_en_cyc), 32'(r));

        // Sink stalls for 20 cycles mid-sweep.
        start_sweep(2'b00, s);
        wait_addr(20);
        out_ready = 1'b0;
        repeat (10) step();
        en_win = 0;
        repeat (10) step();
        chk("stall_no_issue", 32'(en_win), 32'd0);
        chk("stall_buffered", 32'(issued - popped), 32'(SKID));
        chk("stall_valid", 32'(out_valid), 32'd1);
        out_ready = 1'b1;
        wait_done();

        // Writer goes busy for 5 cycles while address 30 is next.
        start_sweep(2'b00, s);
        wait_addr(30);
        wr_busy = 2'b01;
        en_win  = 0;
        repeat (5) step();
        chk("writer_pause_no_issue", 32'(en_win), 32'd0);
        chk("pause_addr_held", 32'(exp_addr), 32'd30);
        wr_busy = 2'b00;
        wait_done();

        // Abort at address 40, then a clean sweep.
        start_sweep(2'b10, s);
        wait_addr(40);
        chk("finish_writer_no_wait", 32'(first_en_cyc), 32'(s + 1));
        rd_abort = 1'b1;
        step();
        rd_abort = 1'b0;
        exp_q.delete();
        sweep_active = 0;
        chk("abort_state", 32'(state), 32'd0);
        chk("abort_valid", 32'(out_valid), 32'd0);
        chk("abort_rd_en", 32'(ram_rd_en), 32'd0);
        repeat (8) step();
        start_sweep(2'b00, s);
        wait_done();
        chk("post_abort_first_en", 32'(first_en_cyc), 32'(s + 1));

        // Random backpressure and writer activity.
        for (int n = 0; n < 2; n++) begin
            start_sweep(2'b00, s);
            t = 0;
            while (popped < LC && t < 5000) begin
                out_ready = 1'($urandom_range(0, 1));
                r = int'($urandom_range(0, 7));
                wr_busy = (r == 0) ? 2'b01 : ((r == 1) ? 2'b10 : 2'b00);
                step();
                t++;
            end
            out_ready = 1'b1;
            wr_busy   = 2'b00;
            wait_done();
        end

        // Reset while draining.
        start_sweep(2'b00, s);
        wait_addr(LC);
        chk("drain_state", 32'(state), 32'd3);
        rstn = 1'b0;
        exp_q.delete();
        sweep_active = 0;
        #1;
        chk("reset_async_outputs", 32'({ram_rd_en, ram_rd_addr, out_valid, out_last, out_data, rd_busy, state}), 32'd0);
        step();
        rstn = 1'b1;
        step();
        chk("post_reset_state", 32'(state), 32'd0);
        chk("post_reset_busy", 32'(rd_busy), 32'd0);
        repeat (4) step();

        report();
        $finish;
    end

endmodule
